// File: rtl/execute_muldiv.sv
// Multi-cycle HI/LO execute unit: iterative shift-add multiply, restoring divide,
// MFHI/MFLO write-back and MTHI/MTLO, with a ready/busy issue interlock.
module execute_muldiv #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic              xm_i_clk,
    input  logic              xm_i_rst,
    input  logic              xm_i_ce,
    input  logic [2:0]        xm_i_op,
    input  logic [DWIDTH-1:0] xm_i_data_rs,
    input  logic [DWIDTH-1:0] xm_i_data_rt,
    input  logic [AWIDTH-1:0] xm_i_addr_rd,
    input  logic              xm_i_flush,
    output logic              xm_o_ready,
    output logic              xm_o_busy,
    output logic              xm_o_done,
    output logic              xm_o_ce,
    output logic [DWIDTH-1:0] xm_o_value,
    output logic [AWIDTH-1:0] xm_o_addr_rd,
    output logic [DWIDTH-1:0] xm_o_hi,
    output logic [DWIDTH-1:0] xm_o_lo
);
    localparam int CW = $clog2(DWIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*DWIDTH-1:0] acc_q, acc_d;
    logic [DWIDTH-1:0]   opnd_q, opnd_d;
    logic                is_div_q, is_div_d;
    logic                neg_lo_q, neg_lo_d;
    logic                neg_hi_q, neg_hi_d;
    logic                div_zero_q, div_zero_d;
    logic [DWIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                done_q, done_d;
    logic                out_ce_q, out_ce_d;
    logic [DWIDTH-1:0]   out_value_q, out_value_d;
    logic [AWIDTH-1:0]   out_addr_q, out_addr_d;

    logic                accept, is_signed, rs_neg, rt_neg;
    logic [DWIDTH-1:0]   rs_mag, rt_mag, quo_fix, rem_fix;
    logic [DWIDTH:0]     mul_sum, div_diff;
    logic [2*DWIDTH-1:0] prod_fix;

    always_comb begin
        accept    = (state_q == S_IDLE) && xm_i_ce && !xm_i_flush;
        // op[2]=0 is mult/div, op[1] selects divide, op[0] selects unsigned / LO
        is_signed = !xm_i_op[2] && !xm_i_op[0];
        rs_neg    = is_signed && xm_i_data_rs[DWIDTH-1];
        rt_neg    = is_signed && xm_i_data_rt[DWIDTH-1];
        rs_mag    = rs_neg ? -xm_i_data_rs : xm_i_data_rs;
        rt_mag    = rt_neg ? -xm_i_data_rt : xm_i_data_rt;
        mul_sum   = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_diff  = acc_q[2*DWIDTH-1:DWIDTH-1] - {1'b0, opnd_q};
        prod_fix  = neg_lo_q ? -acc_q : acc_q;
        quo_fix   = neg_lo_q ? -acc_q[DWIDTH-1:0] : acc_q[DWIDTH-1:0];
        rem_fix   = neg_hi_q ? -acc_q[2*DWIDTH-1:DWIDTH] : acc_q[2*DWIDTH-1:DWIDTH];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        is_div_d    = is_div_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        div_zero_d  = div_zero_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        out_ce_d    = 1'b0;
        out_value_d = '0;
        out_addr_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!xm_i_op[2]) begin
                        state_d    = S_CALC;
                        cnt_d      = CW'(DWIDTH);
                        is_div_d   = xm_i_op[1];
                        neg_lo_d   = rs_neg ^ rt_neg;
                        neg_hi_d   = rs_neg;
                        div_zero_d = (xm_i_data_rt == '0);
                        if (xm_i_op[1]) begin
                            acc_d  = {{DWIDTH{1'b0}}, rs_mag};
                            opnd_d = rt_mag;
                        end else begin
                            acc_d  = {{DWIDTH{1'b0}}, rt_mag};
                            opnd_d = rs_mag;
                        end
                    end else if (!xm_i_op[1]) begin
                        out_ce_d    = 1'b1;
                        out_value_d = xm_i_op[0] ? lo_q : hi_q;
                        out_addr_d  = xm_i_addr_rd;
                    end else if (xm_i_op[0]) begin
                        lo_d = xm_i_data_rs;
                    end else begin
                        hi_d = xm_i_data_rs;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
                // Divide keeps quotient bits in the low half as the dividend shifts out
                if (is_div_q) begin
                    acc_d = div_diff[DWIDTH] ? {acc_q[2*DWIDTH-2:0], 1'b0}
                                             : {div_diff[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {mul_sum, acc_q[DWIDTH-1:1]};
                end
                if (xm_i_flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                if (!xm_i_flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = div_zero_q ? '1 : quo_fix;
                    end else begin
                        hi_d = prod_fix[2*DWIDTH-1:DWIDTH];
                        lo_d = prod_fix[DWIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge xm_i_clk) begin
        if (!xm_i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            is_div_q    <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            div_zero_q  <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            done_q      <= 1'b0;
            out_ce_q    <= 1'b0;
            out_value_q <= '0;
            out_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            is_div_q    <= is_div_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            div_zero_q  <= div_zero_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            done_q      <= done_d;
            out_ce_q    <= out_ce_d;
            out_value_q <= out_value_d;
            out_addr_q  <= out_addr_d;
        end
    end

    assign xm_o_ready   = (state_q == S_IDLE);
    assign xm_o_busy    = (state_q == S_CALC) || (state_q == S_FIX);
    assign xm_o_done    = done_q;
    assign xm_o_ce      = out_ce_q;
    assign xm_o_value   = out_value_q;
    assign xm_o_addr_rd = out_addr_q;
    assign xm_o_hi      = hi_q;
    assign xm_o_lo      = lo_q;
endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench for execute_muldiv: stimulus pushes expected HI/LO or write-back
// records, a negedge monitor pops and compares whenever done or xm_o_ce appears.
module tb_execute_muldiv;
    localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3,
                           OP_MFHI = 3'd4, OP_MFLO = 3'd5, OP_MTHI = 3'd6, OP_MTLO = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs = '0, rt = '0;
    logic [4:0]  rd = '0;
    logic        flush = 1'b0;
    logic        xm_o_ready, xm_o_busy, xm_o_done, xm_o_ce;
    logic [31:0] xm_o_value, xm_o_hi, xm_o_lo;
    logic [4:0]  xm_o_addr_rd;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        bit          is_wb;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    execute_muldiv #(.DWIDTH(32), .AWIDTH(5)) dut (
        .xm_i_clk     (clk),
        .xm_i_rst     (rst),
        .xm_i_ce      (ce),
        .xm_i_op      (op),
        .xm_i_data_rs (rs),
        .xm_i_data_rt (rt),
        .xm_i_addr_rd (rd),
        .xm_i_flush   (flush),
        .xm_o_ready   (xm_o_ready),
        .xm_o_busy    (xm_o_busy),
        .xm_o_done    (xm_o_done),
        .xm_o_ce      (xm_o_ce),
        .xm_o_value   (xm_o_value),
        .xm_o_addr_rd (xm_o_addr_rd),
        .xm_o_hi      (xm_o_hi),
        .xm_o_lo      (xm_o_lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_done(input logic [31:0] hi, input logic [31:0] lo);
        exp_t x;
        x.is_wb = 1'b0; x.a = hi; x.b = lo;
        sbq.push_back(x);
    endtask

    task automatic push_wb(input logic [31:0] val, input logic [4:0] addr);
        exp_t x;
        x.is_wb = 1'b1; x.a = val; x.b = {27'd0, addr};
        sbq.push_back(x);
    endtask

    // Monitor: every done pulse or write-back must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (xm_o_done) begin
                if (sbq.size() == 0 || sbq[0].is_wb) chk("unexpected_done", 64'd1, 64'd0);
                else begin
                    e = sbq.pop_front();
                    chk("done_hi", {32'd0, xm_o_hi}, {32'd0, e.a});
                    chk("done_lo", {32'd0, xm_o_lo}, {32'd0, e.b});
                end
            end
            if (xm_o_ce) begin
                if (sbq.size() == 0 || !sbq[0].is_wb) chk("unexpected_wb", 64'd1, 64'd0);
                else begin
                    e = sbq.pop_front();
                    chk("wb_value", {32'd0, xm_o_value}, {32'd0, e.a});
                    chk("wb_addr", {59'd0, xm_o_addr_rd}, {32'd0, e.b});
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, output int t);
        int n;
        n = 0;
        ce = 1'b1; op = o; rs = a; rt = b; rd = d;
        while (!xm_o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!xm_o_ready) chk("issue_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        t = cyc;
        ce = 1'b0;
    endtask

    task automatic wait_done(output int t);
        t = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (xm_o_done) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    initial begin
        int   ta, td, t2, ndone;
        logic [31:0] hb, lb;
        vec_t vecs[6];
        vecs[0] = '{OP_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{OP_MULTU, 32'd7,        32'hFFFFFFFD, 32'h00000006, 32'hFFFFFFEB};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};

        repeat (2) @(negedge clk);
        chk("rst_ready", {63'd0, xm_o_ready}, 64'd1);
        chk("rst_busy",  {63'd0, xm_o_busy},  64'd0);
        chk("rst_done",  {63'd0, xm_o_done},  64'd0);
        chk("rst_ce",    {63'd0, xm_o_ce},    64'd0);
        chk("rst_value", {32'd0, xm_o_value}, 64'd0);
        chk("rst_addr",  {59'd0, xm_o_addr_rd}, 64'd0);
        chk("rst_hilo",  {xm_o_hi, xm_o_lo},  64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Reset in the middle of a multiply
        issue(OP_MULT, 32'd7, 32'd9, 5'd0, ta);
        repeat (4) @(negedge clk);
        chk("midcalc_busy", {63'd0, xm_o_busy}, 64'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_ready", {63'd0, xm_o_ready}, 64'd1);
        chk("midrst_busy",  {63'd0, xm_o_busy},  64'd0);
        chk("midrst_hilo",  {xm_o_hi, xm_o_lo},  64'd0);
        chk("midrst_done",  {63'd0, xm_o_done},  64'd0);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            push_done(vecs[i].hi, vecs[i].lo);
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt, 5'd0, ta);
            chk("busy_after_issue", {63'd0, xm_o_busy}, 64'd1);
            wait_done(td);
            chk("latency", 64'(td - ta), 64'd33);
            chk("ready_after_done", {63'd0, xm_o_ready}, 64'd1);
        end

        // MFHI held during a DIVU (100/7 -> q=14 r=2) is accepted only once ready
        push_done(32'd2, 32'd14);
        push_wb(32'd2, 5'd9);
        issue(OP_DIVU, 32'd100, 32'd7, 5'd0, ta);
        issue(OP_MFHI, 32'd0, 32'd0, 5'd9, t2);
        chk("mf_stall_accept", 64'(t2 - ta), 64'd34);
        repeat (2) @(negedge clk);

        // MTLO then MFLO back to back
        push_wb(32'h1234, 5'd5);
        issue(OP_MTLO, 32'h1234, 32'd0, 5'd0, ta);
        chk("mtlo_lo", {32'd0, xm_o_lo}, 64'h1234);
        issue(OP_MFLO, 32'd0, 32'd0, 5'd5, t2);
        chk("mf_after_mt_ce", {63'd0, xm_o_ce}, 64'd1);
        issue(OP_MTHI, 32'hABCD, 32'd0, 5'd0, ta);
        chk("mthi_hi", {32'd0, xm_o_hi}, 64'hABCD);
        chk("mt_no_wb", {63'd0, xm_o_ce}, 64'd0);

        // Flush in IDLE blocks acceptance
        ce = 1'b1; op = OP_MTHI; rs = 32'h5555; flush = 1'b1;
        @(negedge clk);
        ce = 1'b0; flush = 1'b0;
        chk("idle_flush_hi", {32'd0, xm_o_hi}, 64'hABCD);

        // Flush at CALC cycle 10 of a DIV
        hb = xm_o_hi; lb = xm_o_lo;
        issue(OP_DIV, 32'd1000, 32'd3, 5'd0, ta);
        repeat (9) @(negedge clk);
        chk("flush_pre_busy", {63'd0, xm_o_busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ready", {63'd0, xm_o_ready}, 64'd1);
        chk("flush_busy",  {63'd0, xm_o_busy},  64'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (xm_o_done) ndone++;
        end
        chk("flush_no_done", 64'(ndone), 64'd0);
        chk("flush_hilo", {xm_o_hi, xm_o_lo}, {hb, lb});

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
